// File: rtl/multi_edge_detector_if.sv
// Signal bundle for multi_edge_detector: raw levels, mode and clear in, edge/event/pending/count/irq out.
interface multi_edge_detector_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
);
  logic [NUM_CH-1:0]       a_i;
  logic [2*NUM_CH-1:0]     mode_i;
  logic [NUM_CH-1:0]       clear_i;
  logic [NUM_CH-1:0]       rising_edge_o;
  logic [NUM_CH-1:0]       falling_edge_o;
  logic [NUM_CH-1:0]       event_o;
  logic [NUM_CH-1:0]       pending_o;
  logic [NUM_CH*CNT_W-1:0] count_o;
  logic                    irq_o;

  modport master (
    output a_i, mode_i, clear_i,
    input  rising_edge_o, falling_edge_o, event_o, pending_o, count_o, irq_o
  );

  modport slave (
    input  a_i, mode_i, clear_i,
    output rising_edge_o, falling_edge_o, event_o, pending_o, count_o, irq_o
  );
endinterface

// File: rtl/multi_edge_detector.sv
// Multi-channel glitch-filtered edge detector with mode-qualified events, sticky pending flags and saturating counters.
// Define EDGE_SYNC_EN to insert a 2-flop synchroniser on every a_i bit ahead of the filter.
module multi_edge_detector #(
  parameter int NUM_CH     = 4,
  parameter int FILTER_LEN = 2,
  parameter int CNT_W      = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  multi_edge_detector_if.slave   edge_bus
);

  localparam int                CW       = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0]     CNT_LAST = CW'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [NUM_CH-1:0] w_s;

`ifdef EDGE_SYNC_EN
  logic [NUM_CH-1:0] r_sync1;
  logic [NUM_CH-1:0] r_sync2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= edge_bus.a_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;
`else
  assign w_s = edge_bus.a_i;
`endif

  logic [NUM_CH-1:0]            r_lvl;
  logic [NUM_CH-1:0][CW-1:0]    r_cnt;
  logic [NUM_CH-1:0]            r_rise;
  logic [NUM_CH-1:0]            r_fall;
  logic [NUM_CH-1:0]            r_evt;
  logic [NUM_CH-1:0]            r_pend;
  logic [NUM_CH-1:0][CNT_W-1:0] r_count;
  logic                         r_irq;

  logic [NUM_CH-1:0]            w_lvl_nxt;
  logic [NUM_CH-1:0][CW-1:0]    w_cnt_nxt;
  logic [NUM_CH-1:0]            w_rise_nxt;
  logic [NUM_CH-1:0]            w_fall_nxt;
  logic [NUM_CH-1:0]            w_evt_nxt;
  logic [NUM_CH-1:0]            w_pend_nxt;
  logic [NUM_CH-1:0][CNT_W-1:0] w_count_nxt;
  logic                         w_irq_nxt;
  logic [NUM_CH-1:0][1:0]       w_mode;

  assign w_mode = edge_bus.mode_i;

  always_comb begin
    w_lvl_nxt   = r_lvl;
    w_cnt_nxt   = '0;
    w_rise_nxt  = '0;
    w_fall_nxt  = '0;
    w_evt_nxt   = '0;
    w_pend_nxt  = r_pend;
    w_count_nxt = r_count;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      // A differing sample must persist FILTER_LEN consecutive clocks; any match restarts the count.
      if (w_s[n] != r_lvl[n]) begin
        if (r_cnt[n] == CNT_LAST) begin
          w_lvl_nxt[n]  = w_s[n];
          w_rise_nxt[n] = w_s[n];
          w_fall_nxt[n] = ~w_s[n];
        end else begin
          w_cnt_nxt[n] = r_cnt[n] + CW'(1);
        end
      end

      w_evt_nxt[n] = (w_rise_nxt[n] & w_mode[n][0]) | (w_fall_nxt[n] & w_mode[n][1]);

      if (w_evt_nxt[n]) begin
        w_pend_nxt[n] = 1'b1;
      end else if (edge_bus.clear_i[n]) begin
        w_pend_nxt[n] = 1'b0;
      end

      // Clear coinciding with an event restarts the count at one rather than zero.
      if (edge_bus.clear_i[n]) begin
        w_count_nxt[n] = w_evt_nxt[n] ? CNT_W'(1) : '0;
      end else if (w_evt_nxt[n] && (r_count[n] != CNT_MAX)) begin
        w_count_nxt[n] = r_count[n] + CNT_W'(1);
      end
    end
    w_irq_nxt = |w_pend_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lvl   <= '0;
      r_cnt   <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
      r_evt   <= '0;
      r_pend  <= '0;
      r_count <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_lvl   <= w_lvl_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_evt   <= w_evt_nxt;
      r_pend  <= w_pend_nxt;
      r_count <= w_count_nxt;
      r_irq   <= w_irq_nxt;
    end
  end

  assign edge_bus.rising_edge_o  = r_rise;
  assign edge_bus.falling_edge_o = r_fall;
  assign edge_bus.event_o        = r_evt;
  assign edge_bus.pending_o      = r_pend;
  assign edge_bus.count_o        = r_count;
  assign edge_bus.irq_o          = r_irq;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Table-driven bench for multi_edge_detector: one FILTER_LEN=1/CNT_W=8 instance and one FILTER_LEN=2/CNT_W=2 instance.
module tb_multi_edge_detector;

`ifdef EDGE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  multi_edge_detector_if #(.NUM_CH(4), .CNT_W(8)) ifa ();
  multi_edge_detector_if #(.NUM_CH(4), .CNT_W(2)) ifb ();

  multi_edge_detector #(.NUM_CH(4), .FILTER_LEN(1), .CNT_W(8)) u_f1 (
    .clk      (clk),
    .reset    (reset),
    .edge_bus (ifa)
  );

  multi_edge_detector #(.NUM_CH(4), .FILTER_LEN(2), .CNT_W(2)) u_f2 (
    .clk      (clk),
    .reset    (reset),
    .edge_bus (ifb)
  );

  typedef struct {
    logic [3:0]  a;
    logic [7:0]  mode;
    logic [3:0]  clr;
    logic [3:0]  rise;
    logic [3:0]  fall;
    logic [3:0]  evt;
    logic [3:0]  pend;
    logic [31:0] cnt;
    logic        irq;
  } vec_t;

  vec_t tbl [32];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic vec_t zv();
    vec_t v;
    v.a = '0; v.mode = '0; v.clr = '0; v.rise = '0; v.fall = '0;
    v.evt = '0; v.pend = '0; v.cnt = '0; v.irq = 1'b0;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
  endtask

  task automatic drive(input int sel, input logic [3:0] a, input logic [7:0] m, input logic [3:0] c);
    if (sel == 0) begin
      ifa.a_i = a; ifa.mode_i = m; ifa.clear_i = c;
    end else begin
      ifb.a_i = a; ifb.mode_i = m; ifb.clear_i = c;
    end
  endtask

  task automatic check_out(input int sel, input string tag, input int idx, input vec_t e);
    logic [3:0]  r, f, ev, p;
    logic [31:0] c;
    logic        q;
    if (sel == 0) begin
      r = ifa.rising_edge_o; f = ifa.falling_edge_o; ev = ifa.event_o;
      p = ifa.pending_o; c = 32'(ifa.count_o); q = ifa.irq_o;
    end else begin
      r = ifb.rising_edge_o; f = ifb.falling_edge_o; ev = ifb.event_o;
      p = ifb.pending_o; c = 32'(ifb.count_o); q = ifb.irq_o;
    end
    check({tag, ".rise"}, idx, 32'(r),  32'(e.rise));
    check({tag, ".fall"}, idx, 32'(f),  32'(e.fall));
    check({tag, ".evt"},  idx, 32'(ev), 32'(e.evt));
    check({tag, ".pend"}, idx, 32'(p),  32'(e.pend));
    check({tag, ".cnt"},  idx, c,       e.cnt);
    check({tag, ".irq"},  idx, 32'(q),  32'(e.irq));
  endtask

  task automatic do_reset();
    drive(0, '0, '0, '0);
    drive(1, '0, '0, '0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // a_i leads mode/clear by LAT cycles so the synchronised build sees the same relative timing.
  task automatic run_table(input int sel, input string tag, input int n);
    vec_t q[$];
    vec_t e;
    for (int t = 0; t < n + LAT; t++) begin
      @(negedge clk);
      drive(sel, tbl[(t < n) ? t : n - 1].a,
            (t >= LAT) ? tbl[t - LAT].mode : 8'h00,
            (t >= LAT) ? tbl[t - LAT].clr  : 4'h0);
      if (t < n) q.push_back(tbl[t]);
      @(posedge clk);
      #1;
      if (t >= LAT) begin
        e = q.pop_front();
        check_out(sel, tag, t - LAT, e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t e;
    int   ev;
    int   cv;

    drive(0, '0, '0, '0);
    drive(1, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    check_out(0, "rst_f1", 0, zv());
    check_out(1, "rst_f2", 0, zv());

    // FILTER_LEN=1, ch0 square wave, both edges enabled
    do_reset();
    for (int k = 0; k < 17; k++) begin
      tbl[k] = zv();
      tbl[k].mode = 8'hFF;
      tbl[k].a    = ((k >= 5 && k < 10) || k >= 15) ? 4'b0001 : 4'b0000;
      tbl[k].rise = (k == 5 || k == 15) ? 4'b0001 : 4'b0000;
      tbl[k].fall = (k == 10) ? 4'b0001 : 4'b0000;
      tbl[k].evt  = tbl[k].rise | tbl[k].fall;
      tbl[k].pend = (k >= 5) ? 4'b0001 : 4'b0000;
      tbl[k].irq  = (k >= 5);
      tbl[k].cnt  = (k >= 15) ? 32'd3 : (k >= 10) ? 32'd2 : (k >= 5) ? 32'd1 : 32'd0;
    end
    run_table(0, "f1_wave", 17);

    // FILTER_LEN=2, 1-cycle glitch rejected then 2-cycle high accepted on ch1
    do_reset();
    for (int k = 0; k < 8; k++) begin
      tbl[k] = zv();
      tbl[k].mode = 8'hFF;
      tbl[k].a    = (k == 1 || k >= 4) ? 4'b0010 : 4'b0000;
      tbl[k].rise = (k == 5) ? 4'b0010 : 4'b0000;
      tbl[k].evt  = tbl[k].rise;
      tbl[k].pend = (k >= 5) ? 4'b0010 : 4'b0000;
      tbl[k].irq  = (k >= 5);
      tbl[k].cnt  = (k >= 5) ? 32'h04 : 32'h00;
    end
    run_table(1, "f2_glitch", 8);

    // per-channel modes 00/01/10/11, all toggle 0->1->0, then clear everything
    do_reset();
    for (int k = 0; k < 10; k++) begin
      tbl[k] = zv();
      tbl[k].mode = 8'hE4;
      tbl[k].a    = (k >= 1 && k <= 3) ? 4'hF : 4'h0;
      tbl[k].clr  = (k == 8) ? 4'hF : 4'h0;
      tbl[k].rise = (k == 2) ? 4'hF : 4'h0;
      tbl[k].fall = (k == 5) ? 4'hF : 4'h0;
      tbl[k].evt  = (k == 2) ? 4'b1010 : (k == 5) ? 4'b1100 : 4'b0000;
      tbl[k].pend = (k >= 8) ? 4'b0000 : (k >= 5) ? 4'b1110 : (k >= 2) ? 4'b1010 : 4'b0000;
      tbl[k].cnt  = (k >= 8) ? 32'h00 : (k >= 5) ? 32'h94 : (k >= 2) ? 32'h44 : 32'h00;
      tbl[k].irq  = (k >= 2 && k < 8);
    end
    run_table(1, "f2_modes", 10);

    // CNT_W=2 saturation on ch2, clear coincident with the 6th rising event
    do_reset();
    for (int k = 0; k < 24; k++) begin
      tbl[k] = zv();
      tbl[k].mode = 8'h10;
      tbl[k].a    = ((k % 4) < 2) ? 4'b0100 : 4'b0000;
      tbl[k].clr  = (k == 21) ? 4'b0100 : 4'b0000;
      tbl[k].rise = ((k % 4) == 1) ? 4'b0100 : 4'b0000;
      tbl[k].fall = ((k % 4) == 3) ? 4'b0100 : 4'b0000;
      tbl[k].evt  = tbl[k].rise;
      tbl[k].pend = (k >= 1) ? 4'b0100 : 4'b0000;
      tbl[k].irq  = (k >= 1);
      ev = (k >= 1) ? ((k - 1) / 4 + 1) : 0;
      cv = (k >= 21) ? 1 : ((ev > 3) ? 3 : ev);
      tbl[k].cnt  = 32'(cv) << 4;
    end
    run_table(1, "f2_sat", 24);

    // reset asserted mid-filter with inputs high, then released with inputs still high
    do_reset();
    drive(0, 4'hF, 8'hFF, 4'h0);
    drive(1, 4'hF, 8'hFF, 4'h0);
    repeat (4 + LAT) @(negedge clk);
    check("pre_rst_f1.pend", 0, 32'(ifa.pending_o), 32'hF);
    check("pre_rst_f2.pend", 0, 32'(ifb.pending_o), 32'hF);
    check("pre_rst_f1.cnt", 0, 32'(ifa.count_o), 32'h01010101);
    check("pre_rst_f2.cnt", 0, 32'(ifb.count_o), 32'h55);
    drive(0, 4'h0, 8'hFF, 4'h0);
    drive(1, 4'h0, 8'hFF, 4'h0);
    repeat (4 + LAT) @(negedge clk);
    drive(0, 4'hF, 8'hFF, 4'h0);
    drive(1, 4'hF, 8'hFF, 4'h0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_out(0, "midrst_f1", 0, zv());
    check_out(1, "midrst_f2", 0, zv());
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
      e = zv();
      e.rise = (c == 1 + LAT) ? 4'hF : 4'h0;
      e.evt  = e.rise;
      e.pend = (c >= 1 + LAT) ? 4'hF : 4'h0;
      e.irq  = (c >= 1 + LAT);
      e.cnt  = (c >= 1 + LAT) ? 32'h01010101 : 32'h0;
      check_out(0, "rel_f1", c, e);
      e = zv();
      e.rise = (c == 2 + LAT) ? 4'hF : 4'h0;
      e.evt  = e.rise;
      e.pend = (c >= 2 + LAT) ? 4'hF : 4'h0;
      e.irq  = (c >= 2 + LAT);
      e.cnt  = (c >= 2 + LAT) ? 32'h55 : 32'h0;
      check_out(1, "rel_f2", c, e);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multi_edge_detector.md
# multi_edge_detector

Multi-channel, glitch-filtered rising/falling edge detector with per-channel event mode, sticky pending flags, saturating event counters and a combined interrupt line. Generalises the single-bit edge detector to NUM_CH independent channels. Sits between raw level inputs (buttons, status lines, handshake strobes) and the control logic or interrupt controller that consumes single-cycle edge events.

## Interface
Parameters:
- NUM_CH, 4, number of independent input channels (≥1).
- FILTER_LEN, 2, consecutive cycles a new level must hold before it is accepted (≥1; 1 = no filtering).
- CNT_W, 8, width of each per-channel event counter (≥1).

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- a_i  input  NUM_CH  raw level inputs, bit n = channel n.
- mode_i  input  2*NUM_CH  per-channel event mode, bits [2n+1:2n]: 00 off, 01 rising, 10 falling, 11 both.
- clear_i  input  NUM_CH  per-channel clear of pending flag and counter.
- rising_edge_o  output  NUM_CH  one-cycle pulse on accepted 0→1 transition (mode-independent).
- falling_edge_o  output  NUM_CH  one-cycle pulse on accepted 1→0 transition (mode-independent).
- event_o  output  NUM_CH  one-cycle pulse: edge pulse qualified by mode_i.
- pending_o  output  NUM_CH  sticky per-channel event flag.
- count_o  output  NUM_CH*CNT_W  per-channel saturating event counts, channel n at [n*CNT_W +: CNT_W].
- irq_o  output  1  OR of all pending_o bits.

## Operation
- Per channel: sample s (a_i[n], or synchroniser output when enabled), filtered level lvl, stability counter cnt (width clog2(FILTER_LEN+1)).
- Each clock: s == lvl → cnt ← 0. s ≠ lvl and cnt == FILTER_LEN-1 → lvl ← s, cnt ← 0, fire edge. Otherwise cnt ← cnt+1.
- Any return of s to lvl before acceptance resets cnt; pulses shorter than FILTER_LEN cycles produce no edge.
- Fired edge: rising_edge_o[n] if new lvl = 1, falling_edge_o[n] if 0. Both never high together on one channel.
- event_o[n] = (rising & mode[0]) | (falling & mode[1]), registered with the edge outputs (same cycle).
- pending_o[n]: set on event_o[n]; cleared by clear_i[n]; simultaneous set and clear → set wins (stays 1).
- count_o channel n: +1 per event_o[n]; saturates at 2^CNT_W-1; clear_i[n] → 0; simultaneous clear and event → 1.
- mode_i and clear_i are sampled on each clock; a mode change affects only edges fired from the next edge onward.
- Channels fully independent; all may fire in the same cycle.

## Timing
- Reset (reset = 0, asynchronous): lvl, cnt, all outputs, counters, pending flags, synchroniser flops → 0. irq_o = 0.
- lvl resets to 0: an input held high through reset release yields one rising edge after the normal latency.
- Latency without sync: a_i changes and stays stable before clock edge k; edge outputs high in the cycle after edge k+FILTER_LEN-1 (FILTER_LEN=1: cycle after edge k).
- Edge/event pulses are exactly one cycle wide; an input that toggles again is re-filtered from scratch.
- pending_o, count_o, irq_o update on the same clock edge that raises event_o (visible concurrently with event_o).
- Reset mid-filter discards any partially counted transition.

## Configuration
- EDGE_SYNC_EN defined: each a_i bit passes through a 2-flop synchroniser (reset to 0) before the filter; latency +2 cycles; a_i may be asynchronous to clk.
- EDGE_SYNC_EN undefined: a_i feeds the filter directly; a_i must be synchronous to clk.

## Test plan
- FILTER_LEN=1, ch0 a_i pattern 0,0,0,0,0,1,1,1,1,1,0,0,0,0,0,1… one sample per cycle, mode 11 → rising_edge_o[0] at sample 5 and 15 (+1 cycle), falling_edge_o[0] at 10 (+1), event_o mirrors, count_o[0] = 3.
- FILTER_LEN=2: 1-cycle high glitch on ch1 → no pulses, count 0; 2-cycle high → rising_edge_o[1] one cycle, 2 cycles after rise.
- Modes: ch0..3 = 00,01,10,11, all toggle 0→1→0 → event_o pulses: ch0 none, ch1 rise only, ch2 fall only, ch3 both; raw edge outputs pulse on all four; pending_o = 4'b1110, irq_o = 1.
- CNT_W=2: 5 rising events on ch2 → count_o[2] = 3 (saturated); clear_i[2] in same cycle as 6th event → count 1, pending_o[2] stays 1.
- Drop reset to 0 mid-filter with a_i high → all outputs 0 immediately; release with a_i still high → single rising pulse after FILTER_LEN cycles (+2 with EDGE_SYNC_EN).
- Clear all channels with no events → pending_o = 0, irq_o deasserts next cycle, counts 0.
